// File: rtl/mem_access_ctrl.sv
// LC-3b MEM-stage access controller: runs LDB/LDW/LDI/STB/STW/STI against the
// data memory with a resp handshake and holds the pipeline until the access retires.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [3:0]  in_opcode,
  input  logic [15:0] in_address,
  input  logic [15:0] in_wdata,
  output logic        stall,
  output logic        out_valid,
  output logic [15:0] out_rdata,
  output logic [15:0] out_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp
);

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_LDW = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_STW = 4'b0111;
  localparam logic [3:0] OP_STI = 4'b1011;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  state_t              state;
  logic [3:0]          op_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   ptr_q;
  logic [DATA_W-1:0]   rdata_q;

  logic in_is_mem;
  logic q_indirect;
  logic q_byte;
  logic q_direct_store;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDB) || (op == OP_LDW) || (op == OP_LDI) ||
           (op == OP_STB) || (op == OP_STW) || (op == OP_STI);
  endfunction

  function automatic logic [DATA_W-1:0] sext_byte(input logic [7:0] b);
    logic signed [7:0]        sb;
    logic signed [DATA_W-1:0] wide;
    sb   = b;
    wide = sb;
    return wide;
  endfunction

  assign in_is_mem      = in_valid && is_mem_op(in_opcode);
  assign q_indirect     = (op_q == OP_LDI) || (op_q == OP_STI);
  assign q_byte         = (op_q == OP_LDB) || (op_q == OP_STB);
  // STI's first access is a pointer read, so only STB/STW write in ACC1.
  assign q_direct_store = (op_q == OP_STB) || (op_q == OP_STW);

  assign out_valid   = in_valid && !stall;
  assign out_rdata   = rdata_q;
  assign out_address = q_indirect ? ptr_q : addr_q;

  always_comb begin
    stall            = 1'b0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = {addr_q[15:1], 1'b0};
    dmem_wdata       = wdata_q;
    dmem_byte_enable = 2'b11;
    case (state)
      IDLE: stall = in_is_mem;
      ACC1: begin
        stall      = 1'b1;
        dmem_read  = !q_direct_store;
        dmem_write = q_direct_store;
        if (q_byte) begin
          dmem_address     = addr_q;
          dmem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
          dmem_wdata       = {wdata_q[7:0], wdata_q[7:0]};
        end
      end
      ACC2: begin
        stall        = 1'b1;
        dmem_address = {ptr_q[15:1], 1'b0};
        dmem_read    = (op_q == OP_LDI);
        dmem_write   = (op_q == OP_STI);
      end
      DONE: stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_is_mem) begin
            op_q    <= in_opcode;
            addr_q  <= in_address;
            wdata_q <= in_wdata;
            state   <= ACC1;
          end
        end
        ACC1: begin
          if (dmem_resp) begin
            if (q_indirect) begin
              ptr_q <= dmem_rdata;
              state <= ACC2;
            end else begin
              if (op_q == OP_LDW)
                rdata_q <= dmem_rdata;
              else if (op_q == OP_LDB)
                rdata_q <= sext_byte(addr_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]);
              state <= DONE;
            end
          end
        end
        ACC2: begin
          if (dmem_resp) begin
            if (op_q == OP_LDI)
              rdata_q <= dmem_rdata;
            state <= DONE;
          end
        end
        // One unstalled cycle lets the pipeline move past the instruction still on the inputs.
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: memory responder checks each access,
// output monitor checks each retired instruction.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [3:0]  in_opcode;
  logic [15:0] in_address;
  logic [15:0] in_wdata;
  logic        stall;
  logic        out_valid;
  logic [15:0] out_rdata;
  logic [15:0] out_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;

  mem_access_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_opcode(in_opcode), .in_address(in_address), .in_wdata(in_wdata),
    .stall(stall), .out_valid(out_valid), .out_rdata(out_rdata), .out_address(out_address),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [15:0] addr; logic [1:0] be; logic [15:0] wdata; } acc_t;
  typedef struct { logic chk; logic [15:0] rdata; logic [15:0] addr; } res_t;

  acc_t acc_q[$];
  res_t res_q[$];
  logic [15:0] mem [logic [15:0]];

  int tests = 0;
  int fails = 0;
  int resp_wait = 0;
  int wcnt = 0;
  bit stray_resp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_acc(input logic wr, input logic [15:0] a, input logic [1:0] be, input logic [15:0] wd);
    acc_t e;
    e.wr = wr; e.addr = a; e.be = be; e.wdata = wd;
    acc_q.push_back(e);
  endtask

  task automatic push_res(input logic c, input logic [15:0] rd, input logic [15:0] a);
    res_t r;
    r.chk = c; r.rdata = rd; r.addr = a;
    res_q.push_back(r);
  endtask

  // Memory responder: answers after resp_wait idle cycles and checks the request it answers.
  always @(negedge clk) begin
    acc_t e;
    logic [15:0] word;
    if (!reset_n) begin
      dmem_resp = 1'b0;
      wcnt = 0;
    end else begin
      if (dmem_resp) wcnt = 0;
      dmem_resp = 1'b0;
      if (stray_resp) begin
        dmem_resp  = 1'b1;
        dmem_rdata = 16'hDEAD;
      end else if (dmem_read || dmem_write) begin
        if (wcnt >= resp_wait) begin
          dmem_resp = 1'b1;
          word = {dmem_address[15:1], 1'b0};
          dmem_rdata = mem.exists(word) ? mem[word] : 16'h0000;
          if (acc_q.size() == 0) begin
            chk("unexpected_access", {15'd0, dmem_write, dmem_address}, 32'd0);
          end else begin
            e = acc_q.pop_front();
            chk("acc_wr_addr_be", {13'd0, dmem_write, dmem_address, dmem_byte_enable},
                {13'd0, e.wr, e.addr, e.be});
            if (e.wr) begin
              chk("acc_wdata", {16'd0, dmem_wdata}, {16'd0, e.wdata});
              if (!mem.exists(word)) mem[word] = 16'h0000;
              if (dmem_byte_enable[0]) mem[word][7:0]  = dmem_wdata[7:0];
              if (dmem_byte_enable[1]) mem[word][15:8] = dmem_wdata[15:8];
            end
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    res_t r;
    if (reset_n && out_valid) begin
      if (res_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        r = res_q.pop_front();
        if (r.chk) begin
          chk("out_rdata", {16'd0, out_rdata}, {16'd0, r.rdata});
          chk("out_address", {16'd0, out_address}, {16'd0, r.addr});
        end
      end
    end
  end

  task automatic issue(input logic v, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] wd, input int w, input int exp_stall, input string name);
    int n;
    bit done;
    resp_wait = w;
    @(posedge clk); #1;
    in_valid = v; in_opcode = op; in_address = a; in_wdata = wd;
    n = 0;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (stall) n++;
      else done = 1;
    end
    if (!done) chk({name, "_timeout"}, 32'd1, 32'd0);
    else chk({name, "_stall_cycles"}, n, exp_stall);
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_opcode = 4'h0; in_address = 16'h0; in_wdata = 16'h0;
    dmem_rdata = 16'h0; dmem_resp = 1'b0;
    mem[16'h3000] = 16'hBEEF;
    mem[16'h4000] = 16'h80FF;
    mem[16'h6000] = 16'h7002;
    mem[16'h7002] = 16'h1234;

    repeat (3) @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_dmem_req", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("rst_out_rdata", {16'd0, out_rdata}, 32'd0);
    chk("rst_out_address", {16'd0, out_address}, 32'd0);
    #2 reset_n = 1'b1;

    push_acc(1'b0, 16'h3000, 2'b11, 16'h0); push_res(1'b1, 16'hBEEF, 16'h3001);
    issue(1'b1, 4'b0110, 16'h3001, 16'h0, 0, 2, "ldw");

    push_acc(1'b0, 16'h4001, 2'b10, 16'h0); push_res(1'b1, 16'hFF80, 16'h4001);
    issue(1'b1, 4'b0010, 16'h4001, 16'h0, 3, 5, "ldb_hi");
    push_acc(1'b0, 16'h4000, 2'b01, 16'h0); push_res(1'b1, 16'hFFFF, 16'h4000);
    issue(1'b1, 4'b0010, 16'h4000, 16'h0, 0, 2, "ldb_lo");

    push_acc(1'b1, 16'h5000, 2'b01, 16'hABAB); push_res(1'b1, 16'hFFFF, 16'h5000);
    issue(1'b1, 4'b0011, 16'h5000, 16'h12AB, 1, 3, "stb");

    push_acc(1'b0, 16'h6000, 2'b11, 16'h0); push_acc(1'b0, 16'h7002, 2'b11, 16'h0);
    push_res(1'b1, 16'h1234, 16'h7002);
    issue(1'b1, 4'b1010, 16'h6000, 16'h0, 0, 3, "ldi");
    push_acc(1'b0, 16'h6000, 2'b11, 16'h0); push_acc(1'b1, 16'h7002, 2'b11, 16'h5A5A);
    push_res(1'b1, 16'h1234, 16'h7002);
    issue(1'b1, 4'b1011, 16'h6000, 16'h5A5A, 2, 7, "sti");

    push_acc(1'b1, 16'h3002, 2'b11, 16'hCAFE); push_res(1'b1, 16'h1234, 16'h3003);
    issue(1'b1, 4'b0111, 16'h3003, 16'hCAFE, 0, 2, "stw");

    push_res(1'b0, 16'h0, 16'h0);
    issue(1'b1, 4'b0001, 16'h1111, 16'h0, 0, 0, "add");
    issue(1'b0, 4'b0110, 16'h3000, 16'h0, 0, 0, "invalid_ldw");

    // Abort an access in ACC1 that memory never answers.
    resp_wait = 1000;
    @(posedge clk); #1;
    in_valid = 1'b1; in_opcode = 4'b0110; in_address = 16'h3000;
    @(negedge clk);
    @(negedge clk);
    chk("abort_read_pending", {31'd0, dmem_read}, 32'd1);
    #2 reset_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("abort_read_drop", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("abort_out_rdata", {16'd0, out_rdata}, 32'd0);
    chk("abort_out_address", {16'd0, out_address}, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #2 reset_n = 1'b1;
    stray_resp = 1;
    @(negedge clk);
    #1 stray_resp = 0;
    @(posedge clk); #1;
    chk("stray_no_req", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("stray_stall", {31'd0, stall}, 32'd0);
    chk("stray_out_rdata", {16'd0, out_rdata}, 32'd0);
    @(negedge clk);

    push_acc(1'b0, 16'h3002, 2'b11, 16'h0); push_res(1'b1, 16'hCAFE, 16'h3002);
    issue(1'b1, 4'b0110, 16'h3002, 16'h0, 0, 2, "ldw_after_rst");

    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("acc_queue_drained", acc_q.size(), 32'd0);
    chk("res_queue_drained", res_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
